// File: rtl/comma_aligner_8b10b.sv
// Receive-side comma aligner for the 8b10b audio link: hunts for K28.5 in the serial
// stream, confirms the phase over several commas, then emits aligned symbols while locked.
module comma_aligner_8b10b #(
    parameter logic [9:0] COMMA_P    = 10'b0011111010,
    parameter int         ACQ_COUNT  = 3,
    parameter int         LOSS_COUNT = 4,
    parameter int         MAX_GAP    = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_bit,
    input  logic       rx_valid,
    output logic [9:0] sym_out,
    output logic       sym_valid,
    output logic       sym_is_comma,
    output logic       locked,
    output logic       realign
);

    localparam int AW = $clog2(ACQ_COUNT + 1);
    localparam int LW = $clog2(LOSS_COUNT + 1);
    localparam int GW = $clog2(MAX_GAP + 1);

    localparam logic [1:0] HUNT  = 2'd0;
    localparam logic [1:0] CHECK = 2'd1;
    localparam logic [1:0] SYNC  = 2'd2;

    logic [1:0]    state, stateNx;
    logic [9:0]    sr, srNx;
    logic [3:0]    bitCnt, bitCntNx;
    logic [AW-1:0] acqCnt, acqCntNx, acqInc;
    logic [LW-1:0] missCnt, missCntNx, missInc;
    logic [GW-1:0] gapCnt, gapCntNx, gapInc;
    logic [9:0]    symOutNx;
    logic          symValidNx, symCommaNx, lockedNx, realignNx;

    logic [9:0] winNext;
    logic       isComma, boundary;

    assign winNext  = {sr[8:0], rx_bit};
    assign isComma  = (winNext == COMMA_P) || (winNext == ~COMMA_P);
    assign boundary = (bitCnt == 4'd9);

    // Counters stop at their thresholds; reaching the threshold is what triggers the transition.
    assign acqInc  = (acqCnt  == AW'(ACQ_COUNT))  ? acqCnt  : acqCnt  + AW'(1);
    assign missInc = (missCnt == LW'(LOSS_COUNT)) ? missCnt : missCnt + LW'(1);
    assign gapInc  = (gapCnt  == GW'(MAX_GAP))    ? gapCnt  : gapCnt  + GW'(1);

    always_comb begin
        stateNx    = state;
        srNx       = sr;
        bitCntNx   = bitCnt;
        acqCntNx   = acqCnt;
        missCntNx  = missCnt;
        gapCntNx   = gapCnt;
        symOutNx   = sym_out;
        symCommaNx = sym_is_comma;
        symValidNx = 1'b0;
        lockedNx   = locked;
        realignNx  = 1'b0;

        if (rx_valid) begin
            srNx     = winNext;
            bitCntNx = boundary ? 4'd0 : bitCnt + 4'd1;

            case (state)
                HUNT: begin
                    if (isComma) begin
                        bitCntNx  = 4'd0;
                        acqCntNx  = AW'(1);
                        gapCntNx  = '0;
                        missCntNx = '0;
                        stateNx   = CHECK;
                    end
                end

                CHECK: begin
                    if (boundary) begin
                        if (isComma) begin
                            acqCntNx = acqInc;
                            gapCntNx = '0;
                            if (acqInc == AW'(ACQ_COUNT)) begin
                                stateNx    = SYNC;
                                lockedNx   = 1'b1;
                                symValidNx = 1'b1;
                                symOutNx   = winNext;
                                symCommaNx = 1'b1;
                                missCntNx  = '0;
                            end
                        end else begin
                            gapCntNx = gapInc;
                            if (gapInc == GW'(MAX_GAP)) begin
                                stateNx  = HUNT;
                                acqCntNx = '0;
                                gapCntNx = '0;
                            end
                        end
                    end else if (isComma) begin
                        // A comma off the tentative phase wins: restart confirmation there.
                        bitCntNx = 4'd0;
                        acqCntNx = AW'(1);
                        gapCntNx = '0;
                    end
                end

                SYNC: begin
                    if (boundary) begin
                        if (isComma) begin
                            gapCntNx   = '0;
                            missCntNx  = '0;
                            symValidNx = 1'b1;
                            symOutNx   = winNext;
                            symCommaNx = 1'b1;
                        end else if (gapInc == GW'(MAX_GAP)) begin
                            // Too long without a comma: drop lock and suppress this symbol.
                            stateNx   = HUNT;
                            lockedNx  = 1'b0;
                            acqCntNx  = '0;
                            gapCntNx  = '0;
                            missCntNx = '0;
                        end else begin
                            gapCntNx   = gapInc;
                            symValidNx = 1'b1;
                            symOutNx   = winNext;
                            symCommaNx = 1'b0;
                        end
                    end else if (isComma) begin
                        if (missInc == LW'(LOSS_COUNT)) begin
                            stateNx   = CHECK;
                            lockedNx  = 1'b0;
                            realignNx = 1'b1;
                            bitCntNx  = 4'd0;
                            acqCntNx  = AW'(1);
                            gapCntNx  = '0;
                            missCntNx = '0;
                        end else begin
                            missCntNx = missInc;
                        end
                    end
                end

                default: begin
                    stateNx  = HUNT;
                    lockedNx = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= HUNT;
            sr           <= '0;
            bitCnt       <= '0;
            acqCnt       <= '0;
            missCnt      <= '0;
            gapCnt       <= '0;
            sym_out      <= '0;
            sym_valid    <= 1'b0;
            sym_is_comma <= 1'b0;
            locked       <= 1'b0;
            realign      <= 1'b0;
        end else begin
            state        <= stateNx;
            sr           <= srNx;
            bitCnt       <= bitCntNx;
            acqCnt       <= acqCntNx;
            missCnt      <= missCntNx;
            gapCnt       <= gapCntNx;
            sym_out      <= symOutNx;
            sym_valid    <= symValidNx;
            sym_is_comma <= symCommaNx;
            locked       <= lockedNx;
            realign      <= realignNx;
        end
    end

endmodule

// File: tb/tb_comma_aligner_8b10b.sv
// Scoreboard bench for comma_aligner_8b10b: stimulus queues expected symbols with their
// due cycle, a negedge monitor pops and compares every sym_valid pulse.
module tb_comma_aligner_8b10b;

    localparam logic [9:0] A = 10'b0011111010;
    localparam logic [9:0] B = 10'b1100000101;
    localparam logic [9:0] D = 10'b1001110100;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_bit;
    logic       rx_valid;
    logic [9:0] sym_out;
    logic       sym_valid;
    logic       sym_is_comma;
    logic       locked;
    logic       realign;

    always #5 clk = ~clk;

    comma_aligner_8b10b #(.MAX_GAP(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_bit       (rx_bit),
        .rx_valid     (rx_valid),
        .sym_out      (sym_out),
        .sym_valid    (sym_valid),
        .sym_is_comma (sym_is_comma),
        .locked       (locked),
        .realign      (realign)
    );

    typedef struct {
        logic [9:0] sym;
        logic       comma;
        int         due;
    } exp_t;

    exp_t q[$];
    exp_t monE;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   toggleMode = 1'b0;
    int   realignCnt = 0;
    int   realignCyc = 0;
    logic realignLocked = 1'b1;
    int   rcExp = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (realign) begin
            realignCnt = realignCnt + 1;
            realignCyc = cyc;
            realignLocked = locked;
        end
        if (sym_valid) begin
            checks = checks + 1;
            if (q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_sym cyc=%0d sym_out=%b comma=%b", cyc, sym_out, sym_is_comma);
            end else begin
                monE = q.pop_front();
                if (sym_out !== monE.sym || sym_is_comma !== monE.comma || locked !== 1'b1 || cyc != monE.due) begin
                    errors = errors + 1;
                    $display("FAIL sym_check got sym=%b comma=%b locked=%b cyc=%0d exp sym=%b comma=%b locked=1 cyc=%0d",
                             sym_out, sym_is_comma, locked, cyc, monE.sym, monE.comma, monE.due);
                end
            end
        end else if (q.size() != 0 && q[0].due <= cyc) begin
            checks = checks + 1;
            errors = errors + 1;
            monE = q.pop_front();
            $display("FAIL missed_sym cyc=%0d exp sym=%b due=%0d", cyc, monE.sym, monE.due);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic sendBit(input logic b, input logic v);
        @(posedge clk);
        #1;
        rx_bit   = b;
        rx_valid = v;
    endtask

    // emitIdx: index of the bit (0 = first sent) whose sampling should produce a pulse; -1 = none.
    task automatic sendSym(input logic [9:0] s, input int emitIdx, input logic [9:0] es, input logic ec);
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            sendBit(s[9-i], 1'b1);
            if (i == emitIdx) begin
                e.sym   = es;
                e.comma = ec;
                e.due   = cyc + 1;
                q.push_back(e);
            end
            if (toggleMode) sendBit(~s[9-i], 1'b0);
        end
    endtask

    task automatic emitSym(input logic [9:0] s, input logic ec);
        sendSym(s, 9, s, ec);
    endtask

    task automatic quietSym(input logic [9:0] s);
        sendSym(s, -1, s, 1'b0);
    endtask

    task automatic garbage();
        sendBit(1'b1, 1'b1); if (toggleMode) sendBit(1'b0, 1'b0);
        sendBit(1'b0, 1'b1); if (toggleMode) sendBit(1'b1, 1'b0);
        sendBit(1'b1, 1'b1); if (toggleMode) sendBit(1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) sendBit(1'b0, 1'b0);
    endtask

    task automatic doReset();
        rx_valid = 1'b0;
        rx_bit   = 1'b0;
        reset    = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rx_valid = 1'b0;
        rx_bit   = 1'b0;
        reset    = 1'b0;
        #2;
        chk("reset_locked", 32'(locked), 32'd0);
        chk("reset_sym_valid", 32'(sym_valid), 32'd0);
        chk("reset_sym_out", 32'(sym_out), 32'd0);
        chk("reset_sym_is_comma", 32'(sym_is_comma), 32'd0);
        chk("reset_realign", 32'(realign), 32'd0);

        // Zeros never form a comma.
        doReset();
        for (int i = 0; i < 20; i++) sendBit(1'b0, 1'b1);
        idle(2);
        chk("zeros_locked", 32'(locked), 32'd0);
        chk("zeros_sym_out", 32'(sym_out), 32'd0);

        // Basic acquisition: third aligned comma locks and is emitted.
        doReset();
        garbage();
        quietSym(A);
        quietSym(B);
        emitSym(A, 1'b1);
        emitSym(B, 1'b1);
        emitSym(A, 1'b1);
        emitSym(B, 1'b1);
        idle(3);
        chk("basic_locked", 32'(locked), 32'd1);

        // Same stream with rx_valid alternating; bits on invalid cycles are inverted junk.
        doReset();
        toggleMode = 1'b1;
        garbage();
        quietSym(A);
        quietSym(B);
        emitSym(A, 1'b1);
        emitSym(B, 1'b1);
        emitSym(A, 1'b1);
        toggleMode = 1'b0;
        idle(3);
        chk("toggle_locked", 32'(locked), 32'd1);

        // One slipped bit: four misaligned commas force a realign, relock two commas later.
        doReset();
        garbage();
        quietSym(A);
        quietSym(B);
        emitSym(A, 1'b1);
        emitSym(B, 1'b1);
        sendBit(1'b0, 1'b1);
        sendSym(A, 8, 10'b0001111101, 1'b0);
        sendSym(B, 8, 10'b0110000010, 1'b0);
        sendSym(A, 8, 10'b1001111101, 1'b0);
        sendSym(B, 8, 10'b0110000010, 1'b0);
        rcExp = cyc + 1;
        quietSym(A);
        chk("realign_unlocked", 32'(locked), 32'd0);
        emitSym(B, 1'b1);
        emitSym(A, 1'b1);
        idle(3);
        chk("realign_count", 32'(realignCnt), 32'd1);
        chk("realign_cycle", 32'(realignCyc), 32'(rcExp));
        chk("realign_locked_low", 32'(realignLocked), 32'd0);
        chk("relock_locked", 32'(locked), 32'd1);

        // Gap timeout with MAX_GAP=16: 15 data pulses, 16th drops lock silently.
        doReset();
        garbage();
        quietSym(A);
        quietSym(B);
        emitSym(A, 1'b1);
        for (int i = 0; i < 15; i++) emitSym(D, 1'b0);
        quietSym(D);
        quietSym(A);
        chk("gap_unlocked", 32'(locked), 32'd0);
        quietSym(B);
        emitSym(A, 1'b1);
        idle(3);
        chk("gap_relock", 32'(locked), 32'd1);

        // Asynchronous reset in the very cycle the lock pulse is showing.
        doReset();
        garbage();
        quietSym(A);
        quietSym(B);
        chk("pre_lock_locked", 32'(locked), 32'd0);
        quietSym(A);
        sendBit(B[9], 1'b1);
        chk("prerst_sym_valid", 32'(sym_valid), 32'd1);
        chk("prerst_locked", 32'(locked), 32'd1);
        chk("prerst_sym_out", 32'(sym_out), 32'(A));
        #1 reset = 1'b0;
        rx_valid = 1'b0;
        #1;
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_sym_valid", 32'(sym_valid), 32'd0);
        chk("rst_sym_out", 32'(sym_out), 32'd0);
        chk("rst_sym_is_comma", 32'(sym_is_comma), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        garbage();
        quietSym(A);
        quietSym(B);
        emitSym(A, 1'b1);
        idle(3);
        chk("rst_relock", 32'(locked), 32'd1);

        idle(2);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
